// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 exhaustive-pattern BIST controller.
// Fault-free signature of the c17 under the default MISR and seed is 8'hB6.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned NUM_PAT   = 32;
  localparam int unsigned PAT_W     = 5;
  localparam logic [7:0]  MISR_POLY = 8'h1D;
  localparam logic [7:0]  MISR_SEED = 8'h00;
  localparam logic [7:0]  GOLDEN    = 8'hB6;

  function automatic logic [7:0] misr_step(
    input logic [7:0] s,
    input logic [7:0] poly,
    input logic [1:0] d
  );
    return {s[6:0], 1'b0}
         ^ (s[7] ? poly : 8'h00)
         ^ {6'b0, d};
  endfunction

endpackage

// File: rtl/c17_misr.sv
// Two-input multiple-input signature register.
// clr reloads the seed and takes priority over a compaction step.
module c17_misr
  import c17_bist_pkg::*;
#(
  parameter logic [7:0] POLY = MISR_POLY,
  parameter logic [7:0] SEED = MISR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] d,
  output logic [7:0] sig
);

  logic [7:0] sig_q;
  logic [7:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = misr_step(sig_q, POLY, d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller: drives all 32 c17 input patterns and compacts the
// two response bits into an 8-bit MISR signature.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned NUM_PAT   = c17_bist_pkg::NUM_PAT,
  parameter logic [7:0]  MISR_POLY = c17_bist_pkg::MISR_POLY,
  parameter logic [7:0]  MISR_SEED = c17_bist_pkg::MISR_SEED,
  parameter logic [7:0]  GOLDEN    = c17_bist_pkg::GOLDEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [4:0] pat,
  input  logic       N22,
  input  logic       N23,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  localparam logic [PAT_W-1:0] LAST = PAT_W'(NUM_PAT - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       resp_q, resp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             misr_clr;
  logic             misr_en;
  logic [7:0]       sig;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    resp_d   = resp_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    if (abort) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      misr_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            misr_clr = 1'b1;
          end
        end
        S_RUN: begin
          resp_d = {N23, N22};
          // resp_q holds nothing valid until the first RUN edge latches it
          misr_en = (cnt_q != '0);
          if (cnt_q == LAST) begin
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + PAT_W'(1);
          end
        end
        S_FLUSH: begin
          misr_en = 1'b1;
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  c17_misr #(
    .POLY (MISR_POLY),
    .SEED (MISR_SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .d     (resp_q),
    .sig   (sig)
  );

  assign pat       = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig;
  assign pass      = done_q && (sig == GOLDEN);

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench for c17_bist_ctrl with a behavioural c17 and
// signature model; fault modes: 0 good, 1 outputs tied 0, 2 N22 stuck-at-1.
module tb_c17_bist_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] pat;
  logic       N22;
  logic       N23;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;

  int         mode  = 0;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] gold;

  c17_bist_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pat       (pat),
    .N22       (N22),
    .N23       (N23),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n1, n2, n3, n6, n7} = p;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [1:0] resp_of(input int m, input logic [4:0] p);
    logic [1:0] r;
    r = c17(p);
    if (m == 1) r = 2'b00;
    else if (m == 2) r[0] = 1'b1;
    return r;
  endfunction

  always_comb begin
    {N23, N22} = resp_of(mode, pat);
  end

  // Signature after compacting all 32 responses, as plain arithmetic
  function automatic logic [7:0] model_sig(input int m);
    int s;
    logic [4:0] p;
    s = 0;
    for (int i = 0; i < 32; i++) begin
      p = 5'(i);
      s = ((s * 2) % 256)
        ^ ((s >= 128) ? 'h1D : 0)
        ^ int'(resp_of(m, p));
    end
    return 8'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pat"}, 32'(pat), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_sig"}, 32'(signature), 0);
  endtask

  // Issue start at a negedge; sample one cycle per negedge after that.
  task automatic run(input int m, input bit noisy, input int abort_at,
                     input int rst_at);
    logic [7:0] exp_sig;
    mode = m;
    exp_sig = model_sig(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      chk("run_pat", 32'(pat), (k > 31) ? 31 : k);
      chk("run_busy", 32'(busy), 1);
      chk("run_done", 32'(done), 0);
      if (k == 0 || m == 1) chk("run_sig_seed", 32'(signature), 0);
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        @(negedge clk);
        chk("abort_stay_busy", 32'(busy), 0);
        return;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle("rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 40; j++) begin
          @(negedge clk);
          if (done !== 1'b0 || busy !== 1'b0) chk("rst_quiet", {busy, done}, 0);
        end
        chk("rst_after_done", 32'(done), 0);
        chk("rst_after_busy", 32'(busy), 0);
        return;
      end
      start = (noisy && k < 32) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_pat", 32'(pat), 31);
    chk("end_sig", 32'(signature), 32'(exp_sig));
    chk("end_pass", 32'(pass), (m == 0) ? 1 : 0);
    if (m == 2) chk("sa1_differs", 32'(signature != gold), 1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("hold_done", 32'(done), 1);
      chk("hold_sig", 32'(signature), 32'(exp_sig));
      chk("hold_pass", 32'(pass), (m == 0) ? 1 : 0);
    end
  endtask

  initial begin
    gold = model_sig(0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    run(0, 1'b0, -1, -1);
    run(0, 1'b1, -1, -1);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_idle("done_start_abort");

    run(1, 1'b0, -1, -1);
    run(2, 1'b0, -1, -1);

    run(0, 1'b0, 10, -1);
    run(0, 1'b0, -1, -1);
    run(0, 1'b1, $urandom_range(1, 31), -1);
    run(0, 1'b0, -1, 20);
    run(0, 1'b0, -1, -1);

    for (int i = 0; i < 3; i++) begin
      run($urandom_range(0, 2), 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c17_bist_ctrl.md
C17_BIST_CTRL -- requirements
Module: c17_bist_ctrl

Interface
REQ-001 Parameter NUM_PAT, default 32: number of exhaustive patterns applied per run, fixed at 2^5.
REQ-002 Parameter MISR_POLY, default 8'h1D: MISR feedback polynomial, x^8+x^4+x^3+x^2+1.
REQ-003 Parameter MISR_SEED, default 8'h00: signature value at the start of a run.
REQ-004 Parameter GOLDEN, default set from the bench reference model: expected fault-free signature.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1 bit: rising-edge clock.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port start, input, 1 bit: single-cycle request to begin a self-test run.
REQ-009 Port abort, input, 1 bit: cancels a run in progress.
REQ-010 Port pat, output, 5 bits: registered stimulus to the c17 under test; bit4..0 drive N1, N2, N3, N6, N7.
REQ-011 Port N22, input, 1 bit: c17 response bit.
REQ-012 Port N23, input, 1 bit: c17 response bit.
REQ-013 Port busy, output, 1 bit: high while the FSM is in RUN or FLUSH.
REQ-014 Port done, output, 1 bit: high while the FSM is in DONE.
REQ-015 Port pass, output, 1 bit: in DONE, equals (signature == GOLDEN); 0 in all other states.
REQ-016 Port signature, output, 8 bits: current MISR contents.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, FLUSH and DONE, with no other reachable state.
REQ-018 IDLE: start=1 SHALL go to RUN, clear the counter, load signature with MISR_SEED and set pat=0.
REQ-019 RUN: pat SHALL equal the counter and increment by 1 each cycle, from 0 to NUM_PAT-1.
REQ-020 RUN: each edge SHALL register {N23,N22} into resp_q; the MISR SHALL absorb resp_q on every edge after the first RUN edge.
REQ-021 MISR update: sig_next = {sig[6:0],0} XOR (sig[7] ? MISR_POLY : 0) XOR {6'b0, resp_q[1], resp_q[0]}.
REQ-022 RUN SHALL go to FLUSH on the edge that latches the response to pat=31; pat SHALL hold 31 in FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle, absorb the final resp_q, then go to DONE.
REQ-024 done SHALL first assert 33 cycles after the edge that sampled start; total MISR updates per run SHALL be exactly 32.
REQ-025 DONE SHALL hold signature, pass and done stable until start or abort.
REQ-026 start in DONE SHALL begin a new run directly, same as from IDLE, with the MISR reseeded.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 abort in RUN, FLUSH or DONE SHALL go to IDLE on the next edge with pat=0, signature=MISR_SEED, pass=0.
REQ-029 abort and start asserted in the same cycle: abort SHALL win.
REQ-030 The counter SHALL never wrap within a run.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, pat=0, counter=0, resp_q=0, signature=MISR_SEED, busy=0, done=0, pass=0.
REQ-032 Reset mid-run SHALL discard the run; no done pulse SHALL follow the reset release.
REQ-033 Outputs SHALL be glitch-free registered values, except pass, which is a registered compare.

Structure
REQ-034 A shared package c17_bist_pkg SHALL hold the state enum, NUM_PAT, MISR_POLY and MISR_SEED.
REQ-035 The MISR SHALL be one sub-module, c17_misr, with ports clk, rst_n, clr, en, d[1:0] and sig[7:0].
REQ-036 The block SHALL contain no combinational path from N22/N23 to any output.

Verification
REQ-037 Bench SHALL cover: start pulse with real c17 attached -> pat steps 0..31 one per cycle; done high at cycle 33; signature==GOLDEN; pass=1.
REQ-038 Bench SHALL cover: N22=N23 tied 0 -> signature stays 8'h00 through the run; done=1; pass=0.
REQ-039 Bench SHALL cover: N22 stuck-at-1 -> final signature differs from GOLDEN; pass=0.
REQ-040 Bench SHALL cover: abort at pat=10 -> next cycle IDLE, pat=0, busy=0, signature=8'h00; a later start yields a full fresh run matching GOLDEN.
REQ-041 Bench SHALL cover: start pulses during RUN -> ignored; run length still 33 cycles; start plus abort in the same cycle while in DONE -> IDLE.
REQ-042 Bench SHALL cover: rst_n low at pat=20 -> all outputs at reset values immediately; no done after release until a new start.
